// File: rtl/demux_stream_pkg.sv
// Shared definitions for the demux_stream block: default geometry and the
// helper that derives the select width from the channel count.
package demux_stream_pkg;

    // Default geometry used when the top level is instantiated without overrides
    localparam int DEF_WIDTH = 10;
    localparam int DEF_NCH   = 2;
    localparam int DEF_ERRW  = 8;

    // Supported channel range
    localparam int MIN_NCH = 2;
    localparam int MAX_NCH = 16;

    // Ceiling log2 with a floor of 1, so a select port always has at least one bit
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/demux_stream_slot.sv
// One-entry output slot of the stream demultiplexer. Holds a word until the
// consumer takes it. Reads as zero while empty. May be drained and reloaded on
// the same edge, so a streaming channel never shows a bubble.
module demux_stream_slot #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             avail
);

    // A slot can take a new word when it is empty or is being drained this cycle
    assign avail = !valid || ready;

    // Slot register: a load wins over a drain, and a plain drain clears the data back to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
            data  <= '0;
        end
    end

endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-NCH stream demultiplexer with per-channel valid/ready.
// Words go to one channel (unicast) or to every channel at once (broadcast).
// Each channel has its own slot, so a stalled consumer only blocks traffic
// that needs its slot. Unicast words aimed past the last channel are
// swallowed and counted in a saturating error counter.
module demux_stream
    import demux_stream_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    parameter int  NCH   = DEF_NCH,
    parameter int  ERRW  = DEF_ERRW,
    localparam int SELW  = sel_width(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SELW-1:0]      in_sel,
    input  logic                 in_bcast,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [ERRW-1:0]      err_cnt
);

    logic [NCH-1:0] avail;
    logic [NCH-1:0] hit;
    logic [NCH-1:0] load;
    logic           sel_legal;
    logic           accept;
    logic           illegal_accept;

    // One-hot decode of the select; an out-of-range select matches no channel
    always_comb begin
        hit = '0;
        for (int i = 0; i < NCH; i++) begin
            if (in_sel == SELW'(i)) begin
                hit[i] = 1'b1;
            end
        end
    end

    assign sel_legal = |hit;

    // Ready depends only on slot availability and the request shape, never on in_valid
    always_comb begin
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = &avail;
        end else if (sel_legal) begin
            in_ready = |(avail & hit);
        end
    end

    assign accept         = in_valid && in_ready;
    assign illegal_accept = accept && !in_bcast && !sel_legal;

    // Load enables: broadcast writes every slot together, unicast writes only the selected slot
    always_comb begin
        load = '0;
        if (accept) begin
            load = in_bcast ? {NCH{1'b1}} : hit;
        end
    end

    // Saturating count of words discarded because of an out-of-range select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (illegal_accept && (err_cnt != {ERRW{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_slot
        demux_stream_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[g]),
            .load_data (in_data),
            .ready     (out_ready[g]),
            .data      (out_data[g*WIDTH +: WIDTH]),
            .valid     (out_valid[g]),
            .avail     (avail[g])
        );
    end

endmodule

// File: tb/tb_demux_stream.sv
// Directed testbench for demux_stream. Instance "a" uses four channels for
// the datapath scenarios; instance "b" uses three channels so that select
// value 3 is out of range and exercises the error counter.
module tb_demux_stream;

    logic clk;
    logic rst;

    logic [9:0]  a_in_data;
    logic [1:0]  a_in_sel;
    logic        a_in_bcast;
    logic        a_in_valid;
    logic        a_in_ready;
    logic [39:0] a_out_data;
    logic [3:0]  a_out_valid;
    logic [3:0]  a_out_ready;
    logic [7:0]  a_err_cnt;

    logic [9:0]  b_in_data;
    logic [1:0]  b_in_sel;
    logic        b_in_bcast;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [29:0] b_out_data;
    logic [2:0]  b_out_valid;
    logic [2:0]  b_out_ready;
    logic [7:0]  b_err_cnt;

    int passed;
    int total;

    demux_stream #(.WIDTH(10), .NCH(4), .ERRW(8)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_data   (a_in_data),
        .in_sel    (a_in_sel),
        .in_bcast  (a_in_bcast),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .err_cnt   (a_err_cnt)
    );

    demux_stream #(.WIDTH(10), .NCH(3), .ERRW(8)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_data   (b_in_data),
        .in_sel    (b_in_sel),
        .in_bcast  (b_in_bcast),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .err_cnt   (b_err_cnt)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_out_ready = 4'b0000;
        a_in_data   = 10'h2AA;
        a_in_sel    = 2'd2;
        a_in_valid  = 1'b1;
        b_out_ready = 3'b000;
        b_in_sel    = 2'd3;
        b_in_valid  = 1'b1;
        step();
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        total++;
        if (a_out_valid !== 4'b0100) $display("[TB] FAIL preload_valid: got %b expected %b", a_out_valid, 4'b0100);
        else passed++;
        total++;
        if (b_err_cnt !== 8'd1) $display("[TB] FAIL preload_err: got %0d expected %0d", b_err_cnt, 1);
        else passed++;
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (a_out_valid !== 4'b0000) $display("[TB] FAIL reset_valid: got %b expected %b", a_out_valid, 4'b0000);
        else passed++;
        total++;
        if (a_out_data !== 40'h0) $display("[TB] FAIL reset_data: got %h expected %h", a_out_data, 40'h0);
        else passed++;
        total++;
        if (b_err_cnt !== 8'd0) $display("[TB] FAIL reset_err: got %0d expected %0d", b_err_cnt, 0);
        else passed++;
        total++;
        if (a_in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected %b", a_in_ready, 1'b1);
        else passed++;
        step();
        rst = 1'b0;
        step();
        step();
        total++;
        if (a_out_valid !== 4'b0000 || a_out_data !== 40'h0)
            $display("[TB] FAIL idle_after_reset: got %b/%h expected 0000/0", a_out_valid, a_out_data);
        else passed++;
    endtask

    task automatic test_unicast();
        a_out_ready = 4'b1111;
        a_in_bcast  = 1'b0;
        a_in_data   = 10'h155;
        a_in_sel    = 2'd2;
        a_in_valid  = 1'b1;
        #1;
        total++;
        if (a_in_ready !== 1'b1) $display("[TB] FAIL uni_in_ready: got %b expected %b", a_in_ready, 1'b1);
        else passed++;
        step();
        a_in_valid = 1'b0;
        total++;
        if (a_out_valid !== 4'b0100) $display("[TB] FAIL uni_valid: got %b expected %b", a_out_valid, 4'b0100);
        else passed++;
        total++;
        if (a_out_data !== 40'h00_1550_0000) $display("[TB] FAIL uni_data: got %h expected %h", a_out_data, 40'h00_1550_0000);
        else passed++;
        step();
        total++;
        if (a_out_valid !== 4'b0000 || a_out_data !== 40'h0)
            $display("[TB] FAIL uni_drain: got %b/%h expected 0000/0", a_out_valid, a_out_data);
        else passed++;
    endtask

    task automatic test_back_pressure();
        a_out_ready = 4'b1101;
        a_in_bcast  = 1'b0;
        a_in_sel    = 2'd1;
        a_in_data   = 10'h0AA;
        a_in_valid  = 1'b1;
        step();
        a_in_data = 10'h033;
        #1;
        total++;
        if (a_in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready_stalled: got %b expected %b", a_in_ready, 1'b0);
        else passed++;
        step();
        total++;
        if (a_out_valid !== 4'b0010 || a_out_data[10 +: 10] !== 10'h0AA)
            $display("[TB] FAIL bp_hold: got %b/%h expected 0010/0aa", a_out_valid, a_out_data[10 +: 10]);
        else passed++;
        a_out_ready = 4'b1111;
        #1;
        total++;
        if (a_in_ready !== 1'b1) $display("[TB] FAIL bp_in_ready_release: got %b expected %b", a_in_ready, 1'b1);
        else passed++;
        step();
        a_in_valid = 1'b0;
        total++;
        if (a_out_valid !== 4'b0010 || a_out_data !== 40'h00_0000_CC00)
            $display("[TB] FAIL bp_reload: got %b/%h expected 0010/000000cc00", a_out_valid, a_out_data);
        else passed++;
        step();
        total++;
        if (a_out_valid !== 4'b0000) $display("[TB] FAIL bp_drain: got %b expected %b", a_out_valid, 4'b0000);
        else passed++;
    endtask

    task automatic test_broadcast();
        a_out_ready = 4'b0111;
        a_in_bcast  = 1'b0;
        a_in_sel    = 2'd3;
        a_in_data   = 10'h001;
        a_in_valid  = 1'b1;
        step();
        a_in_bcast = 1'b1;
        a_in_data  = 10'h2C3;
        #1;
        total++;
        if (a_in_ready !== 1'b0) $display("[TB] FAIL bc_in_ready_blocked: got %b expected %b", a_in_ready, 1'b0);
        else passed++;
        step();
        total++;
        if (a_out_valid !== 4'b1000 || a_out_data !== 40'h00_4000_0000)
            $display("[TB] FAIL bc_no_partial: got %b/%h expected 1000/0040000000", a_out_valid, a_out_data);
        else passed++;
        a_out_ready = 4'b1111;
        #1;
        total++;
        if (a_in_ready !== 1'b1) $display("[TB] FAIL bc_in_ready_release: got %b expected %b", a_in_ready, 1'b1);
        else passed++;
        step();
        a_in_valid = 1'b0;
        a_in_bcast = 1'b0;
        total++;
        if (a_out_valid !== 4'b1111 || a_out_data !== {4{10'h2C3}})
            $display("[TB] FAIL bc_all: got %b/%h expected 1111/%h", a_out_valid, a_out_data, {4{10'h2C3}});
        else passed++;
        step();
        total++;
        if (a_out_valid !== 4'b0000) $display("[TB] FAIL bc_drain: got %b expected %b", a_out_valid, 4'b0000);
        else passed++;
    endtask

    task automatic test_illegal();
        int not_ready;
        int stray;
        not_ready   = 0;
        stray       = 0;
        b_out_ready = 3'b000;
        b_in_bcast  = 1'b0;
        b_in_sel    = 2'd3;
        b_in_valid  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            b_in_data = 10'(i);
            #1;
            if (b_in_ready !== 1'b1) not_ready++;
            step();
            if (b_out_valid !== 3'b000 || b_out_data !== 30'h0) stray++;
            if (i == 253) begin
                total++;
                if (b_err_cnt !== 8'd254) $display("[TB] FAIL ill_err_254: got %0d expected %0d", b_err_cnt, 254);
                else passed++;
            end
        end
        b_in_valid = 1'b0;
        total++;
        if (not_ready !== 0) $display("[TB] FAIL ill_in_ready: got %0d stalled cycles expected 0", not_ready);
        else passed++;
        total++;
        if (stray !== 0) $display("[TB] FAIL ill_no_write: got %0d cycles with slot data expected 0", stray);
        else passed++;
        total++;
        if (b_err_cnt !== 8'd255) $display("[TB] FAIL ill_err_sat: got %0d expected %0d", b_err_cnt, 255);
        else passed++;
    endtask

    task automatic test_independence();
        int not_ready;
        int order_err;
        int ch0_err;
        not_ready   = 0;
        order_err   = 0;
        ch0_err     = 0;
        a_out_ready = 4'b1110;
        a_in_bcast  = 1'b0;
        a_in_sel    = 2'd0;
        a_in_data   = 10'h3A5;
        a_in_valid  = 1'b1;
        step();
        a_in_sel = 2'd1;
        for (int k = 0; k < 20; k++) begin
            a_in_data = 10'h100 + 10'(k);
            #1;
            if (a_in_ready !== 1'b1) not_ready++;
            step();
            if (a_out_valid[1] !== 1'b1 || a_out_data[10 +: 10] !== 10'h100 + 10'(k)) order_err++;
            if (a_out_valid[0] !== 1'b1 || a_out_data[0 +: 10] !== 10'h3A5) ch0_err++;
        end
        a_in_valid = 1'b0;
        total++;
        if (not_ready !== 0) $display("[TB] FAIL ind_in_ready: got %0d stalled cycles expected 0", not_ready);
        else passed++;
        total++;
        if (order_err !== 0) $display("[TB] FAIL ind_ch1_order: got %0d bad words expected 0", order_err);
        else passed++;
        total++;
        if (ch0_err !== 0) $display("[TB] FAIL ind_ch0_stable: got %0d bad cycles expected 0", ch0_err);
        else passed++;
        step();
        total++;
        if (a_out_valid !== 4'b0001 || a_out_data !== 40'h00_0000_03A5)
            $display("[TB] FAIL ind_final: got %b/%h expected 0001/00000003a5", a_out_valid, a_out_data);
        else passed++;
        a_out_ready = 4'b1111;
        step();
    endtask

    // Test sequence
    initial begin
        passed      = 0;
        total       = 0;
        rst         = 1'b1;
        a_in_data   = '0;
        a_in_sel    = '0;
        a_in_bcast  = 1'b0;
        a_in_valid  = 1'b0;
        a_out_ready = '0;
        b_in_data   = '0;
        b_in_sel    = '0;
        b_in_bcast  = 1'b0;
        b_in_valid  = 1'b0;
        b_out_ready = '0;
        step();
        step();
        rst = 1'b0;
        step();
        test_reset();
        test_unicast();
        test_back_pressure();
        test_broadcast();
        test_illegal();
        test_independence();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
